// File: rtl/spike_tx_pkg.sv
// Shared types and width helpers for the spike event transmitter and its FIFO.
package spike_tx_pkg;

    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_PULSE = 2'd1,
        CH_GAP   = 2'd2
    } chan_state_e;

    // Counter must hold p_pulse_len-1 and p_gap-1.
    function automatic int cnt_width(input int pulse_len, input int gap);
        int longest;
        longest = (pulse_len > gap) ? pulse_len : gap;
        return $clog2(longest + 1);
    endfunction

    function automatic int lvl_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Widths for the default configuration (pulse 2, gap 4, depth 8).
    localparam int CNT_W = cnt_width(2, 4);
    localparam int LVL_W = lvl_width(8);

endpackage

// File: rtl/spike_tx_fifo.sv
// Show-ahead FIFO: head entry is visible on o_rd_data whenever o_empty is low.
module spike_tx_fifo
    import spike_tx_pkg::*;
#(
    parameter int p_depth  = 8,
    parameter int p_data_w = 3
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_push,
    input  logic [p_data_w-1:0]            i_wr_data,
    input  logic                           i_pop,
    output logic [p_data_w-1:0]            o_rd_data,
    output logic                           o_full,
    output logic                           o_empty,
    output logic [lvl_width(p_depth)-1:0]  o_level
);
    localparam int AW = $clog2(p_depth);
    localparam int LW = lvl_width(p_depth);

    logic [p_data_w-1:0] mem_q [p_depth];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic                do_push, do_pop;

    assign o_full    = (level_q == LW'(p_depth));
    assign o_empty   = (level_q == '0);
    assign do_push   = i_push & ~o_full;
    assign do_pop    = i_pop & ~o_empty;
    assign o_level   = level_q;
    // Asynchronous read keeps the head visible in the same cycle it is written behind.
    assign o_rd_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= i_wr_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/spike_event_tx.sv
// Queues channel addresses and dispatches them in order as spaced per-channel event pulses.
// Optional pulse counter output enabled with SPIKE_EVENT_TX_STATS_EN.
module spike_event_tx
    import spike_tx_pkg::*;
#(
    parameter int p_chan       = 8,
    parameter int p_addr_w     = 3,
    parameter int p_fifo_depth = 8,
    parameter int p_pulse_len  = 2,
    parameter int p_gap        = 4
) (
    input  logic                                 i_base_clk,
    input  logic                                 i_rst_n,
    input  logic                                 i_valid,
    input  logic [p_addr_w-1:0]                  i_addr,
    output logic                                 o_ready,
    output logic [p_chan:1]                      o_event,
    output logic                                 o_busy,
    output logic [lvl_width(p_fifo_depth)-1:0]   o_level
`ifdef SPIKE_EVENT_TX_STATS_EN
    ,
    output logic [15:0]                          o_sent_cnt
`endif
);
    localparam int CW = cnt_width(p_pulse_len, p_gap);
    localparam logic [CW-1:0] PULSE_LOAD = CW'(p_pulse_len - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'((p_gap > 0) ? p_gap - 1 : 0);

    logic                fifo_full, fifo_empty, pop;
    logic [p_addr_w-1:0] head_addr;
    logic [p_chan-1:0]   head_sel, chan_free, chan_idle, chan_start, chan_event;

    spike_tx_fifo #(
        .p_depth  (p_fifo_depth),
        .p_data_w (p_addr_w)
    ) u_fifo (
        .i_clk     (i_base_clk),
        .i_rst_n   (i_rst_n),
        .i_push    (i_valid),
        .i_wr_data (i_addr),
        .i_pop     (pop),
        .o_rd_data (head_addr),
        .o_full    (fifo_full),
        .o_empty   (fifo_empty),
        .o_level   (o_level)
    );

    // An out-of-range head selects no channel and is popped without a pulse.
    assign pop     = !fifo_empty && (!(|head_sel) || |(head_sel & chan_free));
    assign o_ready = !fifo_full;
    assign o_busy  = !fifo_empty || !(&chan_idle);
    assign o_event = chan_event;

    generate
        for (genvar gi = 0; gi < p_chan; gi++) begin : g_chan
            chan_state_e   state_q, state_d;
            logic [CW-1:0] cnt_q, cnt_d;
            logic          ev_q, ev_d;

            assign head_sel[gi]   = (head_addr == p_addr_w'(gi));
            assign chan_start[gi] = pop & head_sel[gi];
            assign chan_idle[gi]  = (state_q == CH_IDLE);
            // Free also in the last gap (or last pulse with no gap) cycle, so restarts land exactly on the spacing.
            assign chan_free[gi]  = (state_q == CH_IDLE)
                                  || (state_q == CH_GAP && cnt_q == '0)
                                  || (state_q == CH_PULSE && cnt_q == '0 && p_gap == 0);
            assign chan_event[gi] = ev_q;

            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                case (state_q)
                    CH_IDLE: begin
                        if (chan_start[gi]) begin
                            state_d = CH_PULSE;
                            cnt_d   = PULSE_LOAD;
                        end
                    end
                    CH_PULSE: begin
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - CW'(1);
                        end else if (chan_start[gi]) begin
                            cnt_d = PULSE_LOAD;
                        end else if (p_gap == 0) begin
                            state_d = CH_IDLE;
                        end else begin
                            state_d = CH_GAP;
                            cnt_d   = GAP_LOAD;
                        end
                    end
                    CH_GAP: begin
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - CW'(1);
                        end else if (chan_start[gi]) begin
                            state_d = CH_PULSE;
                            cnt_d   = PULSE_LOAD;
                        end else begin
                            state_d = CH_IDLE;
                        end
                    end
                    default: begin
                        state_d = CH_IDLE;
                        cnt_d   = '0;
                    end
                endcase
                ev_d = (state_d == CH_PULSE);
            end

            always_ff @(posedge i_base_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    state_q <= CH_IDLE;
                    cnt_q   <= '0;
                    ev_q    <= 1'b0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    ev_q    <= ev_d;
                end
            end
        end
    endgenerate

`ifdef SPIKE_EVENT_TX_STATS_EN
    logic [15:0] sent_cnt_q, sent_cnt_d;

    always_comb begin
        sent_cnt_d = sent_cnt_q + {15'd0, |chan_start};
    end

    always_ff @(posedge i_base_clk or negedge i_rst_n) begin
        if (!i_rst_n) sent_cnt_q <= '0;
        else          sent_cnt_q <= sent_cnt_d;
    end

    assign o_sent_cnt = sent_cnt_q;
`endif

endmodule

// File: tb/tb_spike_event_tx.sv
// Directed testbench for spike_event_tx at default parameters.
module tb_spike_event_tx;
    import spike_tx_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             valid;
    logic [2:0]       addr;
    logic             ready;
    logic [8:1]       ev;
    logic             busy;
    logic [LVL_W-1:0] level;
`ifdef SPIKE_EVENT_TX_STATS_EN
    logic [15:0]      sent_cnt;
`endif

    int checks = 0;
    int errors = 0;

    spike_event_tx dut (
        .i_base_clk (clk),
        .i_rst_n    (rst_n),
        .i_valid    (valid),
        .i_addr     (addr),
        .o_ready    (ready),
        .o_event    (ev),
        .o_busy     (busy),
        .o_level    (level)
`ifdef SPIKE_EVENT_TX_STATS_EN
        ,
        .o_sent_cnt (sent_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        valid = 1'b0;
        addr  = 3'd0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        valid = 1'b0;
        addr  = 3'd0;
        rst_n = 1'b0;
        #1;
        checks++; if (ev !== 8'h00) begin errors++; $display("FAIL reset_event: got %h expected %h", ev, 8'h00); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (ready !== 1'b1 || busy !== 1'b0 || ev !== 8'h00) begin
            errors++; $display("FAIL post_reset_idle: got ready=%b busy=%b event=%h expected 1 0 00", ready, busy, ev);
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        logic [7:0] exp_ev;
        logic       exp_busy;
        valid = 1'b1; addr = 3'd2;
        tick();
        valid = 1'b0;
        $display("push addr 2");
        checks++; if (level !== 4'd1) begin errors++; $display("FAIL single_level_e0: got %0d expected 1", level); end
        checks++; if (ev !== 8'h00) begin errors++; $display("FAIL single_event_e0: got %h expected 00", ev); end
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_ev   = (k <= 2) ? 8'h04 : 8'h00;
            exp_busy = (k < 7);
            checks++; if (ev !== exp_ev) begin errors++; $display("FAIL single_event_e%0d: got %h expected %h", k, ev, exp_ev); end
            checks++; if (busy !== exp_busy) begin errors++; $display("FAIL single_busy_e%0d: got %b expected %b", k, busy, exp_busy); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_ev;
        logic [3:0] exp_level;
        logic       exp_busy;
        valid = 1'b1; addr = 3'd5;
        tick();
        checks++; if (level !== 4'd1) begin errors++; $display("FAIL b2b_level_e0: got %0d expected 1", level); end
        tick();
        valid = 1'b0;
        $display("push addr 5 twice");
        checks++; if (ev !== 8'h20) begin errors++; $display("FAIL b2b_event_e1: got %h expected 20", ev); end
        checks++; if (level !== 4'd1) begin errors++; $display("FAIL b2b_level_e1: got %0d expected 1", level); end
        for (int k = 2; k <= 13; k++) begin
            tick();
            exp_ev    = (k == 2 || k == 7 || k == 8) ? 8'h20 : 8'h00;
            exp_level = (k < 7) ? 4'd1 : 4'd0;
            exp_busy  = (k < 13);
            checks++; if (ev !== exp_ev) begin errors++; $display("FAIL b2b_event_e%0d: got %h expected %h", k, ev, exp_ev); end
            checks++; if (level !== exp_level) begin errors++; $display("FAIL b2b_level_e%0d: got %0d expected %0d", k, level, exp_level); end
            checks++; if (busy !== exp_busy) begin errors++; $display("FAIL b2b_busy_e%0d: got %b expected %b", k, busy, exp_busy); end
        end
    endtask

    task automatic test_diff_chan();
        logic [7:0] exp_ev;
        logic [3:0] exp_level;
        for (int k = 0; k <= 6; k++) begin
            if (k <= 2) begin
                valid = 1'b1; addr = 3'(k);
                $display("push addr %0d", k);
            end else begin
                valid = 1'b0;
            end
            tick();
            case (k)
                1:       exp_ev = 8'h01;
                2:       exp_ev = 8'h03;
                3:       exp_ev = 8'h06;
                4:       exp_ev = 8'h04;
                default: exp_ev = 8'h00;
            endcase
            exp_level = (k <= 2) ? 4'd1 : 4'd0;
            checks++; if (ev !== exp_ev) begin errors++; $display("FAIL diff_event_e%0d: got %h expected %h", k, ev, exp_ev); end
            checks++; if (level !== exp_level) begin errors++; $display("FAIL diff_level_e%0d: got %0d expected %0d", k, level, exp_level); end
        end
        for (int k = 0; k < 6; k++) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL diff_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_backpressure();
        logic prev1;
        int   rises;
        int   first_full;
        prev1 = 1'b0; rises = 0; first_full = -1;
        valid = 1'b1; addr = 3'd0;
        for (int k = 0; k <= 30; k++) begin
            tick();
            if (ev[1] && !prev1) begin
                $display("pop to channel 0 at cycle %0d", k);
                checks++; if ((k - 1) % 6 != 0) begin errors++; $display("FAIL bp_pop_time: got cycle %0d expected 1+6n", k); end
                rises++;
            end
            prev1 = ev[1];
            if (!ready && first_full < 0) first_full = k;
            if (k == 8 || k == 13) begin
                checks++; if (ready !== 1'b1 || level !== 4'd7) begin
                    errors++; $display("FAIL bp_e%0d: got ready=%b level=%0d expected 1 7", k, ready, level);
                end
            end
            if (k == 9 || k == 14) begin
                checks++; if (ready !== 1'b0 || level !== 4'd8) begin
                    errors++; $display("FAIL bp_full_e%0d: got ready=%b level=%0d expected 0 8", k, ready, level);
                end
            end
        end
        valid = 1'b0;
        checks++; if (first_full != 9) begin errors++; $display("FAIL bp_first_full: got %0d expected 9", first_full); end
        checks++; if (rises != 5) begin errors++; $display("FAIL bp_pop_count: got %0d expected 5", rises); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        valid = 1'b1; addr = 3'd3;
        tick();
        tick();
        tick();
        valid = 1'b0;
        $display("push addr 3 three times");
        checks++; if (ev !== 8'h08) begin errors++; $display("FAIL rmid_pre_event: got %h expected 08", ev); end
        checks++; if (level !== 4'd2) begin errors++; $display("FAIL rmid_pre_level: got %0d expected 2", level); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (ev !== 8'h00) begin errors++; $display("FAIL rmid_async_event: got %h expected 00", ev); end
        checks++; if (level !== 4'd0 || ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL rmid_async_state: got level=%0d ready=%b busy=%b expected 0 1 0", level, ready, busy);
        end
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++; if (ev !== 8'h00 || level !== 4'd0 || ready !== 1'b1) begin
                errors++; $display("FAIL rmid_after_%0d: got event=%h level=%0d ready=%b expected 00 0 1", k, ev, level, ready);
            end
        end
    endtask

`ifdef SPIKE_EVENT_TX_STATS_EN
    task automatic test_stats();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            valid = 1'b1; addr = 3'(k % 8);
            tick();
        end
        valid = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        checks++; if (sent_cnt !== 16'd10) begin errors++; $display("FAIL stats_count: got %0d expected 10", sent_cnt); end
        dut.sent_cnt_q = 16'hFFFF;
        valid = 1'b1; addr = 3'd4;
        tick();
        valid = 1'b0;
        tick();
        tick();
        checks++; if (sent_cnt !== 16'd0) begin errors++; $display("FAIL stats_wrap: got %h expected 0000", sent_cnt); end
    endtask
`endif

    initial begin
        rst_n = 1'b1;
        valid = 1'b0;
        addr  = 3'd0;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_diff_chan();
        test_backpressure();
        test_reset_mid();
`ifdef SPIKE_EVENT_TX_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
